pt_frame_seq: RTL

//  Sequences a full PT2262-style frame: 12 tri-state code bits, then a sync bit, repeated REPEATS times.

---
 rtl/pt_frame_seq_pkg.sv | 22 ++
 rtl/pt_frame_seq_if.sv | 14 +
 rtl/pt_frame_seq_chip_timer.sv | 31 +++
 rtl/pt_frame_seq.sv | 93 +++++++++
 4 files changed

// File: rtl/pt_frame_seq_pkg.sv
// pt_frame_seq_pkg: trit codes, chip patterns, frame geometry and FSM states for the PT2262 frame sequencer
package pt_frame_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CODE = 2'd1, SYNC = 2'd2} state_t;
    localparam logic [1:0] PT_T0 = 2'b00, PT_T1 = 2'b01, PT_TF = 2'b10, PT_TBAD = 2'b11;
    localparam logic [31:0] PT_PAT_0 = 32'hF000F000;
    localparam logic [31:0] PT_PAT_1 = 32'hFFF0FFF0;
    localparam logic [31:0] PT_PAT_F = 32'hF000FFF0;
    localparam int PT_CODE_BITS = 12;
    localparam int PT_BIT_CHIPS = 32;
    localparam int PT_SYNC_CHIPS = 128;
    localparam int PT_SYNC_HIGH = 4;
    // An illegal 11 trit falls through to the F pattern.
    function automatic logic [31:0] pt_pattern(input logic [1:0] t);
        return t == PT_T0 ? PT_PAT_0 : t == PT_T1 ? PT_PAT_1 : PT_PAT_F;
    endfunction
    function automatic logic pt_has_bad(input logic [23:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < PT_CODE_BITS; i++) bad = bad | (w[2*i +: 2] == PT_TBAD);
        return bad;
    endfunction
endpackage

// File: rtl/pt_frame_seq_if.sv
// pt_frame_seq_if: command word handshake and modulator-side status of the frame sequencer
interface pt_frame_seq_if;
    logic [23:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic        tx_out;
    logic        busy;
    logic [3:0]  frame_idx;
    logic        done;
    logic        code_err;
    modport master (output in_word, in_valid, abort, input in_ready, tx_out, busy, frame_idx, done, code_err);
    modport slave (input in_word, in_valid, abort, output in_ready, tx_out, busy, frame_idx, done, code_err);
endinterface

// File: rtl/pt_frame_seq_chip_timer.sv
// pt_frame_seq_chip_timer: chip prescaler plus 7-bit chip counter wrapping at a selectable limit
module pt_frame_seq_chip_timer #(
    parameter int CLKS_PER_CHIP = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [6:0] limit,
    output logic       strobe,
    output logic [6:0] chip,
    output logic [6:0] chip_nx
);
    logic [15:0] presc_q, presc_d;
    logic [6:0]  chip_q;
    assign strobe = en && !clear && presc_q == 16'(CLKS_PER_CHIP - 1);
    assign chip = chip_q;
    always_comb begin
        presc_d = clear ? '0 : strobe ? '0 : en ? presc_q + 16'd1 : presc_q;
        chip_nx = clear ? '0 : strobe ? (chip_q == limit ? '0 : chip_q + 7'd1) : chip_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            chip_q  <= '0;
        end else begin
            presc_q <= presc_d;
            chip_q  <= chip_nx;
        end
    end
endmodule

// File: rtl/pt_frame_seq.sv
// pt_frame_seq: sends REPEATS PT2262 frames (12 trits + sync) per accepted word as a chip stream on tx_out
module pt_frame_seq
    import pt_frame_seq_pkg::*;
#(
    parameter int CLKS_PER_CHIP = 16,
    parameter int REPEATS = 4
) (
    input logic clk,
    input logic rst,
    pt_frame_seq_if.slave bus
);
    state_t      state_q, state_d;
    logic [23:0] word_q, word_d;
    logic [3:0]  trit_q, trit_d, frame_q, frame_d;
    logic        tx_q, tx_d, done_q, done_d, err_q, err_d;
    logic        busy, accept, strobe;
    logic [6:0]  chip, chip_nx, limit;
    logic [1:0]  trit_code;
    logic [31:0] pat;
    assign busy = state_q != IDLE;
    assign bus.in_ready = state_q == IDLE && !rst;
    assign accept = bus.in_valid && bus.in_ready && !bus.abort;
    assign limit = state_q == SYNC ? 7'(PT_SYNC_CHIPS - 1) : 7'(PT_BIT_CHIPS - 1);
    pt_frame_seq_chip_timer #(.CLKS_PER_CHIP(CLKS_PER_CHIP)) u_timer (
        .clk(clk),
        .rst(rst),
        .clear(accept || bus.abort),
        .en(busy),
        .limit(limit),
        .strobe(strobe),
        .chip(chip),
        .chip_nx(chip_nx)
    );
    // tx_out is computed from next-state values so chip 0 appears right after accept, yet stays registered.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        trit_d  = trit_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            state_d = CODE;
            word_d  = bus.in_word;
            trit_d  = '0;
            frame_d = '0;
            err_d   = pt_has_bad(bus.in_word);
        end else if (bus.abort && busy) begin
            state_d = IDLE;
            trit_d  = '0;
            frame_d = '0;
        end else if (strobe && chip == limit) begin
            if (state_q == CODE) begin
                trit_d  = trit_q == 4'(PT_CODE_BITS - 1) ? '0 : trit_q + 4'd1;
                state_d = trit_q == 4'(PT_CODE_BITS - 1) ? SYNC : CODE;
            end else if (frame_q == 4'(REPEATS - 1)) begin
                state_d = IDLE;
                frame_d = '0;
                done_d  = 1'b1;
            end else begin
                state_d = CODE;
                frame_d = frame_q + 4'd1;
            end
        end
        trit_code = 2'(word_d >> (5'd22 - {trit_d, 1'b0}));
        pat = pt_pattern(trit_code);
        tx_d = state_d == CODE ? pat[5'd31 - chip_nx[4:0]] : state_d == SYNC && chip_nx < 7'(PT_SYNC_HIGH);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            trit_q  <= '0;
            frame_q <= '0;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            trit_q  <= trit_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign bus.tx_out = tx_q;
    assign bus.busy = busy;
    assign bus.frame_idx = frame_q;
    assign bus.done = done_q;
    assign bus.code_err = err_q;
endmodule
